// File: rtl/dbg_pkg.sv
// dbg_pkg: shared types and frame constants for the debug program loader.
//   state_e          - loader FSM states
//   SyncByteDefault  - default frame start marker
//   CountBytes       - bytes in the little-endian word-count field
//   WordBytes        - bytes per little-endian instruction word
package dbg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  localparam logic [7:0]  SyncByteDefault = 8'hA5;
  localparam int unsigned CountBytes      = 4;
  localparam int unsigned WordBytes       = 4;

endpackage

// File: rtl/debug_loader_if.sv
// debug_loader_if: groups the host byte stream and the core debug-load port.
//   rx_data/rx_valid       - received byte and its single-cycle strobe
//   DEBUG_SIG              - load in progress
//   DEBUG_addr/DEBUG_instr - word byte-address and instruction for a write
//   DEBUG_we               - one-cycle write strobe
//   core_nrst_o            - active-low reset to the core
//   load_done/load_err     - sticky result of the last frame
// master: the loader side. slave: the host/core side.
interface debug_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        DEBUG_SIG;
  logic [31:0] DEBUG_addr;
  logic [31:0] DEBUG_instr;
  logic        DEBUG_we;
  logic        core_nrst_o;
  logic        load_done;
  logic        load_err;

  modport master (
    input  rx_data, rx_valid,
    output DEBUG_SIG, DEBUG_addr, DEBUG_instr, DEBUG_we, core_nrst_o, load_done, load_err
  );

  modport slave (
    output rx_data, rx_valid,
    input  DEBUG_SIG, DEBUG_addr, DEBUG_instr, DEBUG_we, core_nrst_o, load_done, load_err
  );

endinterface

// File: rtl/byte_assembler.sv
// byte_assembler: little-endian byte-to-word shift register with index counter.
//   clk, nrst     - clock, asynchronous active-low reset
//   clear_i       - restart at byte 0
//   byte_valid_i  - accept byte_i this cycle
//   byte_i        - incoming byte
//   word_o        - assembled word, valid while word_valid_o is high
//   word_valid_o  - combinational pulse in the cycle the last byte of a word arrives
module byte_assembler
  import dbg_pkg::*;
#(
  parameter int unsigned NumBytes = WordBytes
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic [8*NumBytes-1:0] word_o,
  output logic                  word_valid_o
);

  localparam int unsigned IdxW  = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned WordW = 8 * NumBytes;

  logic [IdxW-1:0]    idx_q, idx_d;
  logic [WordW-9:0]   shift_q, shift_d;

  // Bytes enter at the top and shift down, so the first byte ends up in [7:0].
  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = byte_valid_i && (idx_q == IdxW'(NumBytes - 1));

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (byte_valid_i) begin
      shift_d = word_o[WordW-1:8];
      idx_d   = word_valid_o ? '0 : idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/debug_loader.sv
// debug_loader: decodes a framed program image from a host byte stream and writes
// it word by word through the core debug-load port, holding the core in reset
// until a checksum-verified load completes.
//   clk  - load clock
//   nrst - asynchronous active-low reset
//   bus  - debug_loader_if.master (rx byte stream in, debug port and status out)
// Frame: SYNC, count N (4 bytes LE), N words (4 bytes LE), XOR checksum byte.
module debug_loader
  import dbg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault
) (
  input logic            clk,
  input logic            nrst,
  debug_loader_if.master bus
);

  localparam int unsigned      IdleW    = $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT);

  state_e           state_q, state_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      word_cnt_q, word_cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      instr_q, instr_d;
  logic [7:0]       csum_q, csum_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             we_q, we_d;
  logic             sig_q, sig_d;
  logic             core_nrst_q, core_nrst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             asm_clear, asm_valid, asm_word_valid;
  logic [31:0]      asm_word;
  logic             in_frame, rx_sync, timeout, go_err;

  assign in_frame  = state_q inside {StCount, StData, StCsum};
  assign rx_sync   = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign asm_valid = bus.rx_valid && (state_q inside {StCount, StData});
  // The idle count would reach TIMEOUT at this edge.
  assign timeout   = in_frame && !bus.rx_valid && (idle_q >= IdleLast);

  byte_assembler #(
    .NumBytes(WordBytes)
  ) u_asm (
    .clk         (clk),
    .nrst        (nrst),
    .clear_i     (asm_clear),
    .byte_valid_i(asm_valid),
    .byte_i      (bus.rx_data),
    .word_o      (asm_word),
    .word_valid_o(asm_word_valid)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_cnt_d  = word_cnt_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    csum_d      = csum_q;
    idle_d      = idle_q;
    we_d        = 1'b0;
    sig_d       = sig_q;
    core_nrst_d = core_nrst_q;
    done_d      = done_q;
    err_d       = err_q;
    asm_clear   = 1'b0;
    go_err      = 1'b0;

    // Address steps in the cycle after each strobe.
    if (we_q) addr_d = addr_q + 32'd4;

    if (in_frame) begin
      if (bus.rx_valid)          idle_d = '0;
      else if (idle_q != IdleMax) idle_d = idle_q + IdleW'(1);
    end

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (rx_sync) begin
          state_d     = StCount;
          asm_clear   = 1'b1;
          csum_d      = 8'h00;
          idle_d      = '0;
          addr_d      = BASE_ADDR;
          sig_d       = 1'b1;
          core_nrst_d = 1'b0;
          done_d      = 1'b0;
          err_d       = 1'b0;
        end
      end
      StCount: begin
        if (bus.rx_valid) begin
          csum_d = csum_q ^ bus.rx_data;
          if (asm_word_valid) begin
            count_d = asm_word;
            if (asm_word > 32'(MAX_WORDS)) begin
              go_err = 1'b1;
            end else if (asm_word == 32'd0) begin
              state_d = StCsum;
            end else begin
              state_d    = StData;
              word_cnt_d = 32'd0;
              addr_d     = BASE_ADDR;
            end
          end
        end
      end
      StData: begin
        if (bus.rx_valid) begin
          csum_d = csum_q ^ bus.rx_data;
          if (asm_word_valid) begin
            we_d       = 1'b1;
            instr_d    = asm_word;
            word_cnt_d = word_cnt_q + 32'd1;
            if (word_cnt_q == count_q - 32'd1) state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == csum_q) begin
            state_d     = StDone;
            sig_d       = 1'b0;
            core_nrst_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (timeout) go_err = 1'b1;

    // Words already written stay written; the core is simply kept in reset.
    if (go_err) begin
      state_d     = StErr;
      sig_d       = 1'b0;
      core_nrst_d = 1'b0;
      err_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      word_cnt_q  <= '0;
      addr_q      <= BASE_ADDR;
      instr_q     <= '0;
      csum_q      <= '0;
      idle_q      <= '0;
      we_q        <= 1'b0;
      sig_q       <= 1'b0;
      core_nrst_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_cnt_q  <= word_cnt_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      csum_q      <= csum_d;
      idle_q      <= idle_d;
      we_q        <= we_d;
      sig_q       <= sig_d;
      core_nrst_q <= core_nrst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.DEBUG_SIG   = sig_q;
  assign bus.DEBUG_addr  = addr_q;
  assign bus.DEBUG_instr = instr_q;
  assign bus.DEBUG_we    = we_q;
  assign bus.core_nrst_o = core_nrst_q;
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;

endmodule
